// File: rtl/slice_cla_accumulator.sv
// Multi-cycle wide adder: one SLICE-bit slice per cycle, LSB slice first, with a registered
// inter-slice carry and whole-word group G/P accumulation. Optional ovf output: OVERFLOW_FLAG_EN.
module slice_cla_accumulator #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] sum,
    output logic             Cout,
    output logic             G_grp,
    output logic             P_grp,
    output logic             done_valid,
    input  logic             done_ready
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [SLICE-1:0] s;
        logic             gs;
        logic             ps;
    } slice_t;

    // Ripple inside the slice for the sum bits; Gs/Ps are the slice's carry-in-independent terms.
    function automatic slice_t slice_add(input logic [SLICE-1:0] a, input logic [SLICE-1:0] b,
                                         input logic cin);
        slice_t r;
        logic   c;
        c    = cin;
        r.s  = '0;
        r.gs = 1'b0;
        r.ps = 1'b1;
        for (int i = 0; i < SLICE; i++) begin
            r.s[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
            r.gs   = (a[i] & b[i]) | ((a[i] ^ b[i]) & r.gs);
            r.ps   = r.ps & (a[i] ^ b[i]);
        end
        return r;
    endfunction

    state_t           state, state_n;
    logic [WIDTH-1:0] a_p0, b_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             carry_p0, g_acc_p0, p_acc_p0;
    logic [IDX_W-1:0] idx_p0;
    logic             last_slice;
    slice_t           sl;

    assign sl         = slice_add(a_p0[SLICE-1:0], b_p0[SLICE-1:0], carry_p0);
    assign last_slice = (idx_p0 == IDX_W'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start_valid) state_n = RUN;
            RUN:     if (last_slice)  state_n = DONE;
            DONE:    if (done_ready)  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == IDLE);
        done_valid  = (state == DONE);
        sum         = sum_p0;
        Cout        = done_valid & carry_p0;
        G_grp       = done_valid & g_acc_p0;
        P_grp       = done_valid & p_acc_p0;
    end

    // Operand shift registers: the current slice always sits in the low SLICE bits.
    always_ff @(posedge clk) begin
        if (state == IDLE && start_valid) begin
            a_p0 <= A;
            b_p0 <= B;
        end else if (state == RUN) begin
            a_p0 <= a_p0 >> SLICE;
            b_p0 <= b_p0 >> SLICE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p0   <= '0;
            carry_p0 <= 1'b0;
            g_acc_p0 <= 1'b0;
            p_acc_p0 <= 1'b0;
            idx_p0   <= '0;
        end else if (state == IDLE && start_valid) begin
            carry_p0 <= Cin;
            g_acc_p0 <= 1'b0;
            p_acc_p0 <= 1'b1;
            idx_p0   <= '0;
        end else if (state == RUN) begin
            carry_p0 <= sl.gs | (sl.ps & carry_p0);
            g_acc_p0 <= sl.gs | (sl.ps & g_acc_p0);
            p_acc_p0 <= p_acc_p0 & sl.ps;
            sum_p0   <= {sl.s, sum_p0[WIDTH-1:SLICE]};
            idx_p0   <= idx_p0 + 1'b1;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic c_top_p0;

    // Carry into the MSB recovered from its sum bit: c = s ^ a ^ b.
    always_ff @(posedge clk) begin
        if (rst)
            c_top_p0 <= 1'b0;
        else if (state == RUN && last_slice)
            c_top_p0 <= sl.s[SLICE-1] ^ a_p0[SLICE-1] ^ b_p0[SLICE-1];
    end

    assign ovf = done_valid & (c_top_p0 ^ carry_p0);
`endif

endmodule

// File: tb/tb_slice_cla_accumulator.sv
// Directed and random bench for slice_cla_accumulator; expected results queue in a scoreboard
// when operands are driven and are compared when done_valid is seen.
module tb_slice_cla_accumulator;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             Cout, G_grp, P_grp, done_valid;
    logic             done_ready = 1'b0;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf;
`endif

    slice_cla_accumulator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .A(A), .B(B), .Cin(Cin), .sum(sum), .Cout(Cout), .G_grp(G_grp), .P_grp(P_grp),
        .done_valid(done_valid), .done_ready(done_ready)
`ifdef OVERFLOW_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        g;
        logic        p;
        logic        ovf;
        logic        cin;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin);
        exp_t        e;
        logic [32:0] t, gt;
        logic [31:0] lo;
        t     = {1'b0, a} + {1'b0, b} + {32'b0, cin};
        gt    = {1'b0, a} + {1'b0, b};
        lo    = {1'b0, a[30:0]} + {1'b0, b[30:0]} + {31'b0, cin};
        e.sum = t[31:0];
        e.cout = t[32];
        e.g   = gt[32];
        e.p   = &(a ^ b);
        e.ovf = lo[31] ^ t[32];
        e.cin = cin;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input bit push);
        int n = 0;
        while (!start_ready && n < 50) begin
            tick();
            n++;
        end
        check("start_ready_wait", 64'(start_ready), 64'(1));
        A = a;
        B = b;
        Cin = cin;
        start_valid = 1'b1;
        if (push) sb.push_back(model(a, b, cin));
        tick();
        start_valid = 1'b0;
        A = $urandom;
        B = $urandom;
        Cin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("done_timeout", 64'(done_valid), 64'(1));
    endtask

    task automatic check_result(input string tag, output exp_t e);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(0), 64'(1));
            e = model(32'd0, 32'd0, 1'b0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_sum"},  64'(sum),   64'(e.sum));
        check({tag, "_cout"}, 64'(Cout),  64'(e.cout));
        check({tag, "_g"},    64'(G_grp), 64'(e.g));
        check({tag, "_p"},    64'(P_grp), 64'(e.p));
        check({tag, "_inv"},  64'(Cout),  64'(G_grp | (P_grp & e.cin)));
`ifdef OVERFLOW_FLAG_EN
        check({tag, "_ovf"},  64'(ovf),   64'(e.ovf));
`endif
    endtask

    task automatic release_done(input string tag);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check({tag, "_done_drop"}, 64'(done_valid),  64'(0));
        check({tag, "_idle"},      64'(start_ready), 64'(1));
    endtask

    task automatic full_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input int stall);
        int   cyc;
        exp_t e;
        start_op(a, b, cin, 1'b1);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(4));
        repeat (stall) tick();
        check_result(tag, e);
        release_done(tag);
    endtask

    initial begin
        int   cyc;
        exp_t e;
        exp_t e2;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_start_ready", 64'(start_ready), 64'(1));
        check("rst_done_valid",  64'(done_valid),  64'(0));
        check("rst_sum",         64'(sum),         64'(0));
        check("rst_cout",        64'(Cout),        64'(0));
        check("rst_g",           64'(G_grp),       64'(0));
        check("rst_p",           64'(P_grp),       64'(0));

        full_op("t1", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        full_op("t2", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        full_op("t3a", 32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        full_op("t3b", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);

        // Backpressure with a competing start request held high.
        start_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        wait_done(cyc);
        check_result("t4a", e);
        A = 32'hA5A5_0F0F;
        B = 32'h5A5A_F0F1;
        Cin = 1'b1;
        start_valid = 1'b1;
        sb.push_back(model(A, B, Cin));
        repeat (5) begin
            tick();
            check("t4_stall_ready", 64'(start_ready), 64'(0));
            check("t4_stall_valid", 64'(done_valid),  64'(1));
            check("t4_stall_sum",   64'(sum),         64'(e.sum));
            check("t4_stall_cout",  64'(Cout),        64'(e.cout));
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("t4_drop", 64'(done_valid),  64'(0));
        check("t4_idle", 64'(start_ready), 64'(1));
        tick();
        start_valid = 1'b0;
        check("t4_accepted", 64'(start_ready), 64'(0));
        wait_done(cyc);
        check("t4b_latency", 64'(cyc), 64'(4));
        check_result("t4b", e2);
        release_done("t4b");

        // Reset in the second RUN cycle aborts the operation.
        start_op(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_start_ready", 64'(start_ready), 64'(1));
        check("t5_done_valid",  64'(done_valid),  64'(0));
        check("t5_sum",         64'(sum),         64'(0));
        check("t5_cout",        64'(Cout),        64'(0));
        tick();
        check("t5_no_valid",    64'(done_valid),  64'(0));
        start_op(32'd5, 32'd7, 1'b1, 1'b1);
        wait_done(cyc);
        check("t5_sum13", 64'(sum), 64'(13));
        check_result("t5", e);
        release_done("t5");

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            case (i % 8)
                0:       begin ra = $urandom; rb = ~ra; end
                1:       begin ra = $urandom; rb = 32'hFFFF_FFFF - ra + 1; end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            full_op("rnd", ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
